sega_mapper: RTL

Parametrised cartridge memory mapper for the Game Gear / Master System core, sitting between the MMU's cartridge port and the external ROM and cartridge-RAM interfaces. It holds the three slot bank registers and the control register, and detects Z80 write strobes on its own. It translates 16-bit Z80 addresses into ROM or cartridge-RAM addresses. It generalises the original fixed 22-bit Sega mapper in three ways:

- ROM size is configurable.
- Cartridge RAM paging is supported.
- A Codemasters register layout can be selected at build time.

---
 rtl/sggoc_pkg.sv | 52 +++++
 rtl/sega_mapper.sv | 94 +++++++++
 2 files changed

// File: rtl/sggoc_pkg.sv
// Shared Game Gear / Master System core definitions: mapper register map,
// register layouts, slot reset values and ctrl bit positions.
package sggoc_pkg;

    localparam int MODE_SEGA        = 0;
    localparam int MODE_CODEMASTERS = 1;

    localparam logic [15:0] SEGA_CTRL_ADDR  = 16'hFFFC;
    localparam logic [15:0] SEGA_SLOT0_ADDR = 16'hFFFD;
    localparam logic [15:0] SEGA_SLOT1_ADDR = 16'hFFFE;
    localparam logic [15:0] SEGA_SLOT2_ADDR = 16'hFFFF;

    localparam logic [15:0] CM_SLOT0_ADDR = 16'h0000;
    localparam logic [15:0] CM_SLOT1_ADDR = 16'h4000;
    localparam logic [15:0] CM_SLOT2_ADDR = 16'h8000;

    localparam logic [7:0] SLOT0_RST = 8'h00;
    localparam logic [7:0] SLOT1_RST = 8'h01;
    localparam logic [7:0] SLOT2_RST = 8'h02;

    localparam int RAM_EN   = 3;
    localparam int RAM_BANK = 2;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_SLOT0,
        REG_SLOT1,
        REG_SLOT2
    } reg_sel_e;

    function automatic reg_sel_e reg_decode(input logic [15:0] a, input int mode);
        reg_decode = REG_NONE;
        if (mode == MODE_CODEMASTERS) begin
            case (a)
                CM_SLOT0_ADDR: reg_decode = REG_SLOT0;
                CM_SLOT1_ADDR: reg_decode = REG_SLOT1;
                CM_SLOT2_ADDR: reg_decode = REG_SLOT2;
                default:       reg_decode = REG_NONE;
            endcase
        end else begin
            case (a)
                SEGA_CTRL_ADDR:  reg_decode = REG_CTRL;
                SEGA_SLOT0_ADDR: reg_decode = REG_SLOT0;
                SEGA_SLOT1_ADDR: reg_decode = REG_SLOT1;
                SEGA_SLOT2_ADDR: reg_decode = REG_SLOT2;
                default:         reg_decode = REG_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/sega_mapper.sv
// Cartridge mapper: slot/ctrl registers with write-edge detection, and
// combinational translation of Z80 addresses to ROM or cartridge RAM.
module sega_mapper
    import sggoc_pkg::*;
#(
    parameter int ROM_ADDR_W  = 22,
    parameter int CRAM_ADDR_W = 15,
    parameter int MODE        = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [15:0]            addr,
    input  logic [7:0]             di,
    output logic [ROM_ADDR_W-1:0]  rom_addr,
    output logic                   rom_cs,
    output logic [CRAM_ADDR_W-1:0] cram_addr,
    output logic                   cram_cs,
    output logic                   cram_we,
    output logic [7:0]             ctrl
);

    localparam int BANK_W = ROM_ADDR_W - 14;

    logic [7:0] slot0, slot1, slot2, ctrl_q;
    logic       wr_q;
    logic       strobe;
    reg_sel_e   sel;

    // wr_q resets high so a wr held across reset release cannot strobe
    assign strobe = wr & ~wr_q;

    always_comb begin
        sel = reg_decode(addr, MODE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b1;
            slot0  <= SLOT0_RST;
            slot1  <= SLOT1_RST;
            slot2  <= SLOT2_RST;
            ctrl_q <= '0;
        end else begin
            wr_q <= wr;
            if (strobe) begin
                case (sel)
                    REG_CTRL:  ctrl_q <= di;
                    REG_SLOT0: slot0  <= di;
                    REG_SLOT1: slot1  <= di;
                    REG_SLOT2: slot2  <= di;
                    default:   ;
                endcase
            end
        end
    end

    assign ctrl = ctrl_q;

    // Truncating {slot, offset} to ROM_ADDR_W keeps only the low bank bits,
    // so oversized bank numbers wrap modulo the ROM size.
    always_comb begin
        rom_addr  = '0;
        rom_cs    = 1'b0;
        cram_addr = '0;
        cram_cs   = 1'b0;
        case (addr[15:14])
            2'b00: begin
                rom_cs = 1'b1;
                if (MODE == MODE_SEGA && addr[13:10] == 4'h0)
                    rom_addr = {{BANK_W{1'b0}}, addr[13:0]};
                else
                    rom_addr = ROM_ADDR_W'({slot0, addr[13:0]});
            end
            2'b01: begin
                rom_cs   = 1'b1;
                rom_addr = ROM_ADDR_W'({slot1, addr[13:0]});
            end
            2'b10: begin
                if (MODE == MODE_SEGA && ctrl_q[RAM_EN]) begin
                    cram_cs   = 1'b1;
                    cram_addr = CRAM_ADDR_W'({ctrl_q[RAM_BANK], addr[13:0]});
                end else begin
                    rom_cs   = 1'b1;
                    rom_addr = ROM_ADDR_W'({slot2, addr[13:0]});
                end
            end
            default: ;
        endcase
    end

    assign cram_we = wr & cram_cs;

endmodule
